id_operand_fetch: RTL and testbench
===================================

Name: id_operand_fetch

Overview:
- Decode-stage requester for the two combinational register-file read ports; it is the reader side of the register file.
- Takes a fetched RV32I instruction, drives read enables/addresses, and resolves RAW hazards by forwarding from EX, MEM and WB.
- Generates the immediate and registers a decoded operand bundle into an ID/EX pipeline register with a valid/ready handshake.
- Stalls on load-use hazards.

Parameters:
XLEN, 32, data/address width
RAW, 5, register address width

Ports:
dclk  in  1  clock
rst  in  1  reset
if_valid_i  in  1  instruction valid from IF
if_ready_o  out  1  ID accepts instruction this cycle
if_inst_i  in  32  instruction word
if_pc_i  in  XLEN  instruction PC
re1_o / re2_o  out  1  read enables to register file
raddr1_o / raddr2_o  out  RAW  read addresses (inst[19:15] / inst[24:20])
rdata1_i / rdata2_i  in  XLEN  read data (combinational, same cycle)
ex_fwd_we_i, ex_fwd_waddr_i, ex_fwd_wdata_i, ex_fwd_is_load_i  in  1/RAW/XLEN/1  EX-stage result
mem_fwd_we_i, mem_fwd_waddr_i, mem_fwd_wdata_i  in  1/RAW/XLEN  MEM-stage result
wb_we_i, wb_waddr_i, wb_wdata_i  in  1/RAW/XLEN  write port currently committing to register file
flush_i  in  1  kill instruction in ID and ID/EX register
ex_ready_i  in  1  EX accepts bundle
ex_valid_o  out  1  bundle valid
ex_pc_o, ex_op1_o, ex_op2_o, ex_imm_o  out  XLEN  PC, rs1 value, rs2 value, immediate
ex_rd_o  out  RAW  destination register
ex_we_o  out  1  writes rd (forced 0 when rd==0)
ex_opcode_o  out  7  opcode
ex_funct3_o  out  3  funct3
ex_funct7b5_o  out  1  inst[30]
ex_illegal_o  out  1  unrecognised opcode

Behaviour:
- Reset: rst is synchronous, active-high; clock is dclk. On reset all ex_* outputs are cleared to 0, including ex_valid_o. if_ready_o is 0 while rst is high.
- Register use by opcode:
  - rs1 used: JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used: BRANCH, STORE, OP.
  - re1_o/re2_o are 1 only when if_valid_i is high and the operand is used. An unused operand yields value 0.
- Immediate generation (sign-extended from inst[31]):
  - I-type: LOAD, OP-IMM, JALR.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC (inst[31:12]<<12).
  - J-type: JAL.
  - OP: 0.
- rd and write enable: ex_we_o=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP when rd!=0.
- Any other opcode: ex_illegal_o=1, ex_we_o=0, bundle still passed downstream.
- Forwarding per used operand, priority EX > MEM > WB > rdata:
  - A source matches only if its we=1, its waddr equals the operand address, and the address is nonzero.
  - Operand address 0 always yields 0, regardless of forwarding.
  - WB forwarding is required because the register file writes at posedge and reads stale data in that cycle.
- Load-use stall = if_valid_i & ex_fwd_is_load_i & ex_fwd_we_i & ex_fwd_waddr_i!=0 & (waddr matches a used rs1 or rs2). MEM/WB loads need no stall.
- Handshake:
  - if_ready_o = !rst & !flush_i & !stall & (!ex_valid_o | ex_ready_i).
  - Accept = if_valid_i & if_ready_o. On accept, the bundle is registered next edge and ex_valid_o=1.
  - If ex_ready_i & ex_valid_o and there is no accept, ex_valid_o<=0.
  - While ex_valid_o & !ex_ready_i, all ex_* outputs hold stable.
  - Stall with a free register: ex_valid_o<=0 (bubble); the instruction stays at IF (not consumed).
- Flush: flush_i=1 gives ex_valid_o<=0 next edge and nothing is accepted that cycle. Priority: rst > flush > accept.
- Latency: 1 cycle from accept to ex_valid_o. Throughput: 1 instruction/cycle with no hazards.

Test Plan:
- Reset: rst=1 for 2 cycles with if_valid_i=1 -> ex_valid_o=0, if_ready_o=0, all ex_* outputs 0.
- ADDI x1,x0,5 (0x00500093) -> next cycle ex_valid_o=1, op1=0, imm=5, rd=1, we=1, re2_o=0.
- ADD x3,x1,x2 (0x002081B3):
  - rdata1=10, rdata2=20, EX fwd x1=7, MEM fwd x1=9, WB x2=33 -> op1=7, op2=33.
  - Repeat with ex_fwd_waddr=0 and we=1 -> op1 uses MEM value 9.
- Load-use: ex_fwd_is_load=1, waddr=1, inst ADD x3,x1,x2 -> if_ready_o=0, ex_valid_o=0 next cycle; drop is_load -> accepted next cycle.
- Backpressure: ex_ready_i=0 for 3 cycles with a valid bundle -> outputs stable, if_ready_o=0; ex_ready_i=1 -> next instruction accepted the same cycle.
- Flush with ex_valid_o=1 and if_valid_i=1 -> ex_valid_o=0 next edge, no accept. Opcode 0x7F -> ex_illegal_o=1, ex_we_o=0.

Source files
------------

// File: rtl/id_operand_fetch.sv
// id_operand_fetch: RV32I decode-stage operand fetch with forwarding, load-use stall and ID/EX register
module id_operand_fetch #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic            dclk,
  input  logic            rst,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_inst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            re1_o,
  output logic            re2_o,
  output logic [RAW-1:0]  raddr1_o,
  output logic [RAW-1:0]  raddr2_o,
  input  logic [XLEN-1:0] rdata1_i,
  input  logic [XLEN-1:0] rdata2_i,
  input  logic            ex_fwd_we_i,
  input  logic [RAW-1:0]  ex_fwd_waddr_i,
  input  logic [XLEN-1:0] ex_fwd_wdata_i,
  input  logic            ex_fwd_is_load_i,
  input  logic            mem_fwd_we_i,
  input  logic [RAW-1:0]  mem_fwd_waddr_i,
  input  logic [XLEN-1:0] mem_fwd_wdata_i,
  input  logic            wb_we_i,
  input  logic [RAW-1:0]  wb_waddr_i,
  input  logic [XLEN-1:0] wb_wdata_i,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [RAW-1:0]  ex_rd_o,
  output logic            ex_we_o,
  output logic [6:0]      ex_opcode_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_funct7b5_o,
  output logic            ex_illegal_o
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_OPI = 7'b0010011, OP_OP = 7'b0110011;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rd;
    logic            we;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            f7b5;
    logic            illegal;
  } bundle_t;
  logic [31:0] i;
  logic [6:0] opc;
  logic [RAW-1:0] rs1, rs2, rd;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
  logic use1, use2, illegal, wr, stall, accept, valid_q, valid_d;
  logic [XLEN-1:0] imm, op1, op2;
  bundle_t bun_d, bun_q;
  assign i = if_inst_i;
  assign opc = i[6:0];
  assign rs1 = i[15 +: RAW];
  assign rs2 = i[20 +: RAW];
  assign rd = i[7 +: RAW];
  assign is_lui = opc == OP_LUI;
  assign is_auipc = opc == OP_AUIPC;
  assign is_jal = opc == OP_JAL;
  assign is_jalr = opc == OP_JALR;
  assign is_br = opc == OP_BR;
  assign is_ld = opc == OP_LD;
  assign is_st = opc == OP_ST;
  assign is_opi = opc == OP_OPI;
  assign is_op = opc == OP_OP;
  assign use1 = is_jalr | is_br | is_ld | is_st | is_opi | is_op;
  assign use2 = is_br | is_st | is_op;
  assign illegal = !(is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_opi | is_op);
  assign wr = (is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op) & (rd != '0);
  assign imm = (is_ld | is_opi | is_jalr) ? {{(XLEN-12){i[31]}}, i[31:20]} :
               is_st ? {{(XLEN-12){i[31]}}, i[31:25], i[11:7]} :
               is_br ? {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
               (is_lui | is_auipc) ? XLEN'($signed({i[31:12], 12'b0})) :
               is_jal ? {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0} : '0;
  assign re1_o = if_valid_i & use1;
  assign re2_o = if_valid_i & use2;
  assign raddr1_o = rs1;
  assign raddr2_o = rs2;
  function automatic logic [XLEN-1:0] fwd(input logic [RAW-1:0] a, input logic [XLEN-1:0] rf);
    return a == '0 ? '0 :
           (ex_fwd_we_i && ex_fwd_waddr_i == a) ? ex_fwd_wdata_i :
           (mem_fwd_we_i && mem_fwd_waddr_i == a) ? mem_fwd_wdata_i :
           (wb_we_i && wb_waddr_i == a) ? wb_wdata_i : rf;
  endfunction
  // operand resolution: youngest producer wins, x0 and unused operands read as zero
  always_comb begin
    op1 = use1 ? fwd(rs1, rdata1_i) : '0;
    op2 = use2 ? fwd(rs2, rdata2_i) : '0;
  end
  assign stall = if_valid_i & ex_fwd_is_load_i & ex_fwd_we_i & (ex_fwd_waddr_i != '0) &
                 ((use1 & (ex_fwd_waddr_i == rs1)) | (use2 & (ex_fwd_waddr_i == rs2)));
  assign if_ready_o = !rst & !flush_i & !stall & (!valid_q | ex_ready_i);
  assign accept = if_valid_i & if_ready_o;
  assign valid_d = flush_i ? 1'b0 : accept ? 1'b1 : ex_ready_i ? 1'b0 : valid_q;
  assign bun_d = '{pc: if_pc_i, op1: op1, op2: op2, imm: imm, rd: rd, we: wr, opcode: opc,
                   funct3: i[14:12], f7b5: i[30], illegal: illegal};
  // ID/EX register: loads only on accept so a stalled consumer sees a stable bundle
  always_ff @(posedge dclk) begin
    if (rst) begin
      valid_q <= 1'b0;
      bun_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) bun_q <= bun_d;
    end
  end
  assign ex_valid_o = valid_q;
  assign ex_pc_o = bun_q.pc;
  assign ex_op1_o = bun_q.op1;
  assign ex_op2_o = bun_q.op2;
  assign ex_imm_o = bun_q.imm;
  assign ex_rd_o = bun_q.rd;
  assign ex_we_o = bun_q.we;
  assign ex_opcode_o = bun_q.opcode;
  assign ex_funct3_o = bun_q.funct3;
  assign ex_funct7b5_o = bun_q.f7b5;
  assign ex_illegal_o = bun_q.illegal;
endmodule

// File: tb/tb_id_operand_fetch.sv
// tb_id_operand_fetch: vector table plus hazard/backpressure/flush sequences with a scoreboard queue
module tb_id_operand_fetch;
  logic dclk = 1'b0, rst, if_valid_i, if_ready_o, re1_o, re2_o;
  logic [31:0] if_inst_i, if_pc_i, rdata1_i, rdata2_i, ex_fwd_wdata_i, mem_fwd_wdata_i, wb_wdata_i;
  logic [4:0] raddr1_o, raddr2_o, ex_fwd_waddr_i, mem_fwd_waddr_i, wb_waddr_i, ex_rd_o;
  logic ex_fwd_we_i, ex_fwd_is_load_i, mem_fwd_we_i, wb_we_i, flush_i, ex_ready_i;
  logic ex_valid_o, ex_we_o, ex_funct7b5_o, ex_illegal_o;
  logic [31:0] ex_pc_o, ex_op1_o, ex_op2_o, ex_imm_o;
  logic [6:0] ex_opcode_o;
  logic [2:0] ex_funct3_o;
  always #5 dclk = ~dclk;
  id_operand_fetch dut (
    .dclk(dclk), .rst(rst), .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_inst_i(if_inst_i),
    .if_pc_i(if_pc_i), .re1_o(re1_o), .re2_o(re2_o), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
    .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .ex_fwd_we_i(ex_fwd_we_i), .ex_fwd_waddr_i(ex_fwd_waddr_i),
    .ex_fwd_wdata_i(ex_fwd_wdata_i), .ex_fwd_is_load_i(ex_fwd_is_load_i), .mem_fwd_we_i(mem_fwd_we_i),
    .mem_fwd_waddr_i(mem_fwd_waddr_i), .mem_fwd_wdata_i(mem_fwd_wdata_i), .wb_we_i(wb_we_i),
    .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
    .ex_imm_o(ex_imm_o), .ex_rd_o(ex_rd_o), .ex_we_o(ex_we_o), .ex_opcode_o(ex_opcode_o),
    .ex_funct3_o(ex_funct3_o), .ex_funct7b5_o(ex_funct7b5_o), .ex_illegal_o(ex_illegal_o)
  );
  typedef struct {
    logic [31:0] inst, rd1, rd2, exd, md, wd, op1, op2, imm;
    logic exwe, exld, mwe, wwe, we, ill, re1, re2;
    logic [4:0] exa, ma, wa, rd;
  } vec_t;
  typedef struct {
    logic [31:0] pc, op1, op2, imm;
    logic [4:0] rd;
    logic we, ill, f7;
    logic [6:0] opc;
    logic [2:0] f3;
  } exp_t;
  localparam int NV = 15;
  vec_t vt[NV];
  exp_t sb[$];
  exp_t cur;
  int checks = 0, failures = 0;
  function automatic vec_t mk(input logic [31:0] inst, rd1, rd2, input logic exwe, input logic [4:0] exa,
                              input logic [31:0] exd, input logic exld, mwe, input logic [4:0] ma,
                              input logic [31:0] md, input logic wwe, input logic [4:0] wa,
                              input logic [31:0] wd, op1, op2, imm, input logic [4:0] rd,
                              input logic we, ill, re1, re2);
    vec_t v;
    v.inst = inst; v.rd1 = rd1; v.rd2 = rd2; v.exwe = exwe; v.exa = exa; v.exd = exd; v.exld = exld;
    v.mwe = mwe; v.ma = ma; v.md = md; v.wwe = wwe; v.wa = wa; v.wd = wd; v.op1 = op1; v.op2 = op2;
    v.imm = imm; v.rd = rd; v.we = we; v.ill = ill; v.re1 = re1; v.re2 = re2;
    return v;
  endfunction
  function automatic exp_t mkexp(input logic [31:0] pc, inst, op1, op2, imm, input logic [4:0] rd,
                                 input logic we, ill);
    exp_t e;
    e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm; e.rd = rd; e.we = we; e.ill = ill;
    e.opc = inst[6:0]; e.f3 = inst[14:12]; e.f7 = inst[30];
    return e;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle();
    rdata1_i = '0; rdata2_i = '0; flush_i = 1'b0;
    ex_fwd_we_i = 1'b0; ex_fwd_waddr_i = '0; ex_fwd_wdata_i = '0; ex_fwd_is_load_i = 1'b0;
    mem_fwd_we_i = 1'b0; mem_fwd_waddr_i = '0; mem_fwd_wdata_i = '0;
    wb_we_i = 1'b0; wb_waddr_i = '0; wb_wdata_i = '0;
  endtask
  task automatic cyc();
    exp_t e;
    if (ex_valid_o && ex_ready_i) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: got unexpected bundle pc %h expected none", ex_pc_o);
      end else begin
        e = sb.pop_front();
        chk("pc", ex_pc_o, e.pc);
        chk("op1", ex_op1_o, e.op1);
        chk("op2", ex_op2_o, e.op2);
        chk("imm", ex_imm_o, e.imm);
        chk("rd", 32'(ex_rd_o), 32'(e.rd));
        chk("we", 32'(ex_we_o), 32'(e.we));
        chk("illegal", 32'(ex_illegal_o), 32'(e.ill));
        chk("opcode", 32'(ex_opcode_o), 32'(e.opc));
        chk("funct3", 32'(ex_funct3_o), 32'(e.f3));
        chk("funct7b5", 32'(ex_funct7b5_o), 32'(e.f7));
      end
    end
    if (if_valid_i && if_ready_o) sb.push_back(cur);
    @(posedge dclk);
    #1;
  endtask
  initial begin
    vt[0]  = mk(32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0);
    vt[1]  = mk(32'h002081B3, 10, 20, 1, 1, 7, 0, 1, 1, 9, 1, 2, 33, 7, 33, 0, 3, 1, 0, 1, 1);
    vt[2]  = mk(32'h002081B3, 10, 20, 1, 0, 7, 0, 1, 1, 9, 1, 2, 33, 9, 33, 0, 3, 1, 0, 1, 1);
    vt[3]  = mk(32'h002081B3, 10, 20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 20, 0, 3, 1, 0, 1, 1);
    vt[4]  = mk(32'hFE20AE23, 32'h100, 32'h200, 0, 0, 0, 0, 1, 2, 32'h55, 0, 0, 0, 32'h100, 32'h55, 32'hFFFFFFFC, 5'h1C, 0, 0, 1, 1);
    vt[5]  = mk(32'hFE208CE3, 5, 32'h66, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h77, 32'h77, 32'h66, 32'hFFFFFFF8, 5'h19, 0, 0, 1, 1);
    vt[6]  = mk(32'h123452B7, 32'hAA, 32'hBB, 1, 8, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345000, 5, 1, 0, 0, 0);
    vt[7]  = mk(32'hFFDFF0EF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 1, 1, 0, 0, 0);
    vt[8]  = mk(32'h00008067, 32'h10, 0, 1, 1, 32'h99, 0, 0, 0, 0, 0, 0, 0, 32'h99, 0, 0, 0, 0, 0, 1, 0);
    vt[9]  = mk(32'h00C12203, 32'h1000, 0, 1, 12, 5, 1, 0, 0, 0, 0, 0, 0, 32'h1000, 0, 12, 4, 1, 0, 1, 0);
    vt[10] = mk(32'h40838333, 32'h30, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h30, 32'h10, 0, 6, 1, 0, 1, 1);
    vt[11] = mk(32'h000000FF, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    vt[12] = mk(32'h00001517, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 10, 1, 0, 0, 0);
    vt[13] = mk(32'h002001B3, 32'h44, 32'h22, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22, 0, 3, 1, 0, 1, 1);
    vt[14] = mk(32'h00108013, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 1, 0);
    idle();
    rst = 1'b1; if_valid_i = 1'b1; if_inst_i = 32'h00500093; if_pc_i = '0; ex_ready_i = 1'b1;
    @(posedge dclk); #1;
    chk("rst_if_ready", 32'(if_ready_o), 0);
    @(posedge dclk); #1;
    chk("rst_ex_valid", 32'(ex_valid_o), 0);
    chk("rst_if_ready2", 32'(if_ready_o), 0);
    chk("rst_ex_pc", ex_pc_o, 0);
    chk("rst_ex_op1", ex_op1_o, 0);
    chk("rst_ex_imm", ex_imm_o, 0);
    chk("rst_ex_misc", {ex_rd_o, ex_we_o, ex_opcode_o, ex_funct3_o, ex_funct7b5_o, ex_illegal_o}, 0);
    rst = 1'b0;
    for (int k = 0; k < NV; k++) begin
      rdata1_i = vt[k].rd1; rdata2_i = vt[k].rd2;
      ex_fwd_we_i = vt[k].exwe; ex_fwd_waddr_i = vt[k].exa; ex_fwd_wdata_i = vt[k].exd; ex_fwd_is_load_i = vt[k].exld;
      mem_fwd_we_i = vt[k].mwe; mem_fwd_waddr_i = vt[k].ma; mem_fwd_wdata_i = vt[k].md;
      wb_we_i = vt[k].wwe; wb_waddr_i = vt[k].wa; wb_wdata_i = vt[k].wd;
      if_inst_i = vt[k].inst; if_pc_i = 32'h1000 + 32'(4 * k); if_valid_i = 1'b1;
      cur = mkexp(if_pc_i, vt[k].inst, vt[k].op1, vt[k].op2, vt[k].imm, vt[k].rd, vt[k].we, vt[k].ill);
      #1;
      chk($sformatf("v%0d_if_ready", k), 32'(if_ready_o), 1);
      chk($sformatf("v%0d_re1", k), 32'(re1_o), 32'(vt[k].re1));
      chk($sformatf("v%0d_re2", k), 32'(re2_o), 32'(vt[k].re2));
      cyc();
      chk($sformatf("v%0d_ex_valid", k), 32'(ex_valid_o), 1);
    end
    idle(); if_valid_i = 1'b0;
    #1; cyc();
    chk("drain_ex_valid", 32'(ex_valid_o), 0);
    if_inst_i = 32'h002081B3; if_pc_i = 32'h2000; if_valid_i = 1'b1;
    rdata1_i = 10; rdata2_i = 20;
    ex_fwd_we_i = 1'b1; ex_fwd_waddr_i = 1; ex_fwd_wdata_i = 7; ex_fwd_is_load_i = 1'b1;
    cur = mkexp(32'h2000, 32'h002081B3, 7, 20, 0, 3, 1, 0);
    #1;
    chk("lu_if_ready", 32'(if_ready_o), 0);
    cyc();
    chk("lu_bubble", 32'(ex_valid_o), 0);
    ex_fwd_is_load_i = 1'b0;
    #1;
    chk("lu_if_ready_after", 32'(if_ready_o), 1);
    cyc();
    chk("lu_accept", 32'(ex_valid_o), 1);
    idle(); ex_ready_i = 1'b0;
    if_inst_i = 32'h123452B7; if_pc_i = 32'h2004;
    cur = mkexp(32'h2004, 32'h123452B7, 0, 0, 32'h12345000, 5, 1, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_if_ready", 32'(if_ready_o), 0);
      chk("bp_ex_valid", 32'(ex_valid_o), 1);
      chk("bp_hold_pc", ex_pc_o, 32'h2000);
      chk("bp_hold_op1", ex_op1_o, 7);
      cyc();
    end
    ex_ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 32'(if_ready_o), 1);
    cyc();
    chk("bp_next_valid", 32'(ex_valid_o), 1);
    chk("bp_next_imm", ex_imm_o, 32'h12345000);
    flush_i = 1'b1; ex_ready_i = 1'b0;
    if_inst_i = 32'h0000007F; if_pc_i = 32'h2008;
    cur = mkexp(32'h2008, 32'h0000007F, 0, 0, 0, 0, 0, 1);
    #1;
    chk("fl_if_ready", 32'(if_ready_o), 0);
    cyc();
    sb.delete();
    chk("fl_ex_valid", 32'(ex_valid_o), 0);
    flush_i = 1'b0; ex_ready_i = 1'b1;
    #1; cyc();
    chk("ill_ex_valid", 32'(ex_valid_o), 1);
    chk("ill_flag", 32'(ex_illegal_o), 1);
    chk("ill_we", 32'(ex_we_o), 0);
    if_valid_i = 1'b0;
    #1; cyc();
    chk("end_ex_valid", 32'(ex_valid_o), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
